// File: rtl/ahb_lite_pkg.sv
// Shared AHB-Lite bus encodings and the memory-slave FSM state constants.
package ahb_lite_pkg;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'd0,
    HTRANS_BUSY   = 2'd1,
    HTRANS_NONSEQ = 2'd2,
    HTRANS_SEQ    = 2'd3
  } htrans_e;

  typedef enum logic [2:0] {
    HSIZE_BYTE  = 3'd0,
    HSIZE_HALF  = 3'd1,
    HSIZE_WORD  = 3'd2,
    HSIZE_DWORD = 3'd3
  } hsize_e;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef logic [2:0] slv_state_e;

  localparam slv_state_e ST_IDLE = 3'd0;
  localparam slv_state_e ST_WAIT = 3'd1;
  localparam slv_state_e ST_DATA = 3'd2;
  localparam slv_state_e ST_ERR1 = 3'd3;
  localparam slv_state_e ST_ERR2 = 3'd4;

endpackage

// File: rtl/ahb_lite_sram_be.sv
// DEPTH x DATA_WIDTH storage with a byte-enable synchronous write port and an
// asynchronous read port. Contents are deliberately not reset.
module ahb_lite_sram_be #(
  parameter int  DATA_WIDTH = 32,
  parameter int  DEPTH      = 256,
  localparam int STRB_W     = DATA_WIDTH / 8,
  localparam int IDX_W      = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [IDX_W-1:0]      waddr,
  input  logic [STRB_W-1:0]     wstrb,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [IDX_W-1:0]      raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Byte-lane write: only strobed lanes of the addressed word change.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (wstrb[i]) begin
          mem_q[waddr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/ahb_lite_mem_slave.sv
// AHB-Lite slave memory model: pipelined address/data phases, programmable
// wait states, byte-lane writes, RAW forwarding and a two-cycle ERROR response.
module ahb_lite_mem_slave
  import ahb_lite_pkg::*;
#(
  parameter int  DATA_WIDTH = 32,
  parameter int  ADDR_WIDTH = 32,
  parameter int  DEPTH      = 256,
  parameter int  MAX_WAIT   = 7,
  localparam int W          = $clog2(MAX_WAIT + 1)
) (
  input  logic                  hclk,
  input  logic                  hrst,
  input  logic                  hsel,
  input  logic [ADDR_WIDTH-1:0] haddr,
  input  logic [1:0]            htrans,
  input  logic                  hwrite,
  input  logic [2:0]            hsize,
  input  logic [DATA_WIDTH-1:0] hwdata,
  input  logic                  hready,
  input  logic [W-1:0]          cfg_wait,
  output logic                  hreadyout,
  output logic                  hresp,
  output logic [DATA_WIDTH-1:0] hrdata
);

  localparam int STRB_W    = DATA_WIDTH / 8;
  localparam int BYTE_BITS = $clog2(STRB_W);
  localparam int IDX_W     = $clog2(DEPTH);

  function automatic logic [STRB_W-1:0] lane_strobe(input logic [2:0] size,
                                                    input logic [BYTE_BITS-1:0] off);
    logic [7:0] base;
    case (size)
      HSIZE_BYTE:  base = 8'h01;
      HSIZE_HALF:  base = 8'h03;
      HSIZE_WORD:  base = 8'h0f;
      HSIZE_DWORD: base = 8'hff;
      default:     base = 8'h00;
    endcase
    return STRB_W'(base) << off;
  endfunction

  function automatic logic [2:0] align_mask(input logic [2:0] size);
    logic [2:0] mask;
    case (size)
      HSIZE_BYTE:  mask = 3'b000;
      HSIZE_HALF:  mask = 3'b001;
      HSIZE_WORD:  mask = 3'b011;
      HSIZE_DWORD: mask = 3'b111;
      default:     mask = 3'b111;
    endcase
    return mask;
  endfunction

  slv_state_e            state_q, state_d;
  logic [W-1:0]          cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [STRB_W-1:0]     strb_q, strb_d;
  logic                  write_q, write_d;
  logic                  hreadyout_q, hreadyout_d;
  logic                  hresp_q, hresp_d;
  logic [DATA_WIDTH-1:0] hrdata_q, hrdata_d;

  logic                  accept_s;
  logic                  illegal_s;
  logic [ADDR_WIDTH-1:0] word_idx_s;
  logic [W-1:0]          cfg_eff_s;
  logic                  we_s;
  logic                  fwd_hit_s;
  logic [DATA_WIDTH-1:0] rd_word_s;
  logic [DATA_WIDTH-1:0] fwd_word_s;

  // A write data phase in DATA retires on this edge unless reset wins.
  assign we_s = (state_q == ST_DATA) && write_q && !hrst;

  ahb_lite_sram_be #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_sram (
    .clk   (hclk),
    .we    (we_s),
    .waddr (idx_q),
    .wstrb (strb_q),
    .wdata (hwdata),
    .raddr (word_idx_s[IDX_W-1:0]),
    .rdata (rd_word_s)
  );

  // Address-phase decode: accept, legality, effective wait count, forwarded read word.
  always_comb begin
    accept_s   = hsel && hready && ((htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ));
    word_idx_s = haddr >> BYTE_BITS;
    illegal_s  = (word_idx_s >= ADDR_WIDTH'(DEPTH))
              || (hsize > 3'(BYTE_BITS))
              || ((haddr[2:0] & align_mask(hsize)) != 3'd0);
    if (int'(cfg_wait) > MAX_WAIT) begin
      cfg_eff_s = W'(MAX_WAIT);
    end else begin
      cfg_eff_s = cfg_wait;
    end
    fwd_hit_s  = we_s && (idx_q == word_idx_s[IDX_W-1:0]);
    fwd_word_s = rd_word_s;
    for (int i = 0; i < STRB_W; i++) begin
      if (fwd_hit_s && strb_q[i]) begin
        fwd_word_s[8*i +: 8] = hwdata[8*i +: 8];
      end else begin
        fwd_word_s[8*i +: 8] = rd_word_s[8*i +: 8];
      end
    end
  end

  // FSM next state, address-phase capture and registered response outputs.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    strb_d   = strb_q;
    write_d  = write_q;
    hrdata_d = hrdata_q;
    case (state_q)
      ST_WAIT: begin
        cnt_d = cnt_q - W'(1);
        if (cnt_q == W'(1)) begin
          state_d = ST_DATA;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_ERR1: begin
        state_d = ST_ERR2;
      end
      ST_IDLE, ST_DATA, ST_ERR2: begin
        if (accept_s) begin
          idx_d   = word_idx_s[IDX_W-1:0];
          strb_d  = lane_strobe(hsize, haddr[BYTE_BITS-1:0]);
          write_d = hwrite;
          cnt_d   = cfg_eff_s;
          if (illegal_s) begin
            state_d  = ST_ERR1;
            hrdata_d = {DATA_WIDTH{1'b0}};
          end else begin
            if (cfg_eff_s != W'(0)) begin
              state_d = ST_WAIT;
            end else begin
              state_d = ST_DATA;
            end
            if (hwrite) begin
              hrdata_d = {DATA_WIDTH{1'b0}};
            end else begin
              hrdata_d = fwd_word_s;
            end
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    hreadyout_d = (state_d != ST_WAIT) && (state_d != ST_ERR1);
    if ((state_d == ST_ERR1) || (state_d == ST_ERR2)) begin
      hresp_d = HRESP_ERROR;
    end else begin
      hresp_d = HRESP_OKAY;
    end
  end

  // State and output registers; reset abandons any transfer in flight.
  always_ff @(posedge hclk) begin
    if (hrst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= {W{1'b0}};
      idx_q       <= {IDX_W{1'b0}};
      strb_q      <= {STRB_W{1'b0}};
      write_q     <= 1'b0;
      hreadyout_q <= 1'b1;
      hresp_q     <= HRESP_OKAY;
      hrdata_q    <= {DATA_WIDTH{1'b0}};
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      strb_q      <= strb_d;
      write_q     <= write_d;
      hreadyout_q <= hreadyout_d;
      hresp_q     <= hresp_d;
      hrdata_q    <= hrdata_d;
    end
  end

  assign hreadyout = hreadyout_q;
  assign hresp     = hresp_q;
  assign hrdata    = hrdata_q;

endmodule

// File: tb/tb_ahb_lite_mem_slave.sv
// Scoreboard bench for ahb_lite_mem_slave: a pipelined master pushes expected
// responses from a byte-array reference model; a monitor checks each data phase.
module tb_ahb_lite_mem_slave;

  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        hrst = 1'b1;
  logic        hsel = 1'b0;
  logic [31:0] haddr = 32'd0;
  logic [1:0]  htrans = 2'd0;
  logic        hwrite = 1'b0;
  logic [2:0]  hsize = 3'd0;
  logic [31:0] hwdata = 32'd0;
  logic [2:0]  cfg_wait = 3'd0;
  logic        force_low = 1'b0;
  logic        hready;
  logic        hreadyout;
  logic        hresp;
  logic [31:0] hrdata;

  assign hready = force_low ? 1'b0 : hreadyout;

  ahb_lite_mem_slave #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (32),
    .DEPTH      (DEPTH),
    .MAX_WAIT   (7)
  ) dut (
    .hclk      (clk),
    .hrst      (hrst),
    .hsel      (hsel),
    .haddr     (haddr),
    .htrans    (htrans),
    .hwrite    (hwrite),
    .hsize     (hsize),
    .hwdata    (hwdata),
    .hready    (hready),
    .cfg_wait  (cfg_wait),
    .hreadyout (hreadyout),
    .hresp     (hresp),
    .hrdata    (hrdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          err;
    bit          rd;
    logic [31:0] data;
    int          waits;
  } exp_t;

  exp_t        exp_q[$];
  int          chk_cnt = 0;
  int          pass_cnt = 0;
  bit          dphase = 1'b0;
  logic [7:0]  mem_b [0:DEPTH*4-1];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // Reference model: a flat little-endian byte array of the slave's address space.
  function automatic bit legal(input logic [31:0] a, input logic [2:0] sz);
    if (a >= 32'(DEPTH * 4)) return 1'b0;
    if (sz > 3'd2) return 1'b0;
    if ((a % (32'd1 << sz)) != 32'd0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [2:0] sz, input logic [31:0] d);
    int lane;
    for (int b = 0; b < (1 << sz); b++) begin
      lane = int'(a % 4) + b;
      mem_b[int'(a) + b] = d[8*lane +: 8];
    end
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] a);
    int w;
    w = int'(a) & ~3;
    return {mem_b[w+3], mem_b[w+2], mem_b[w+1], mem_b[w]};
  endfunction

  task automatic wait_ready();
    int   n = 0;
    logic r;
    do begin
      @(negedge clk);
      r = hready;
      n++;
      @(posedge clk);
      #1;
    end while (r !== 1'b1 && n < 40);
    if (r !== 1'b1) begin
      chk_cnt++;
      $display("FAIL accept_timeout: hready stayed low for %0d cycles, expected 1", n);
    end
  endtask

  task automatic issue(input bit w, input logic [31:0] a, input logic [2:0] sz,
                       input logic [31:0] d, input logic [2:0] cw, input bit apply,
                       input bit ovr, input logic [31:0] ovr_val);
    exp_t e;
    hsel     = 1'b1;
    htrans   = 2'd2;
    haddr    = a;
    hwrite   = w;
    hsize    = sz;
    cfg_wait = cw;
    e.err    = !legal(a, sz);
    e.rd     = !w;
    e.waits  = e.err ? 1 : int'(cw);
    if (!e.err && w && apply) model_write(a, sz, d);
    if (e.err) e.data = 32'd0;
    else if (ovr) e.data = ovr_val;
    else e.data = model_read(a);
    exp_q.push_back(e);
    wait_ready();
    hwdata = d;
  endtask

  task automatic go_idle();
    hsel   = 1'b0;
    htrans = 2'd0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || dphase) && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("drain_done", 32'(exp_q.size()), 32'd0);
  endtask

  // Monitor: decides data-phase boundaries from bus signals, pops and compares.
  initial begin : monitor
    exp_t e;
    int   waits_seen;
    bit   wait_resp_bad;
    waits_seen    = 0;
    wait_resp_bad = 1'b0;
    forever begin
      @(negedge clk);
      if (hrst) begin
        if (dphase && exp_q.size() > 0) void'(exp_q.pop_front());
        dphase        = 1'b0;
        waits_seen    = 0;
        wait_resp_bad = 1'b0;
      end else if (dphase && hreadyout !== 1'b1) begin
        waits_seen++;
        if (exp_q.size() > 0 && hresp !== exp_q[0].err) wait_resp_bad = 1'b1;
      end else if (dphase) begin
        chk("queue_nonempty", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("wait_cycles", 32'(waits_seen), 32'(e.waits));
          chk("wait_resp", 32'(wait_resp_bad), 32'd0);
          chk("resp", 32'(hresp), 32'(e.err));
          if (e.rd) chk("rdata", hrdata, e.data);
        end
        waits_seen    = 0;
        wait_resp_bad = 1'b0;
        dphase        = hsel && hready && htrans[1];
      end else begin
        chk("idle_ready", 32'(hreadyout), 32'd1);
        chk("idle_resp", 32'(hresp), 32'd0);
        dphase = hsel && hready && htrans[1];
      end
    end
  end

  initial begin : driver
    logic [31:0] a;
    logic [2:0]  sz;
    logic [2:0]  cw;
    int          kind;
    repeat (3) @(posedge clk);
    #1;
    hrst = 1'b0;

    for (int i = 0; i < DEPTH; i++) issue(1'b1, 32'(i * 4), 3'd2, $urandom(), 3'd0, 1'b1, 1'b0, 32'd0);
    go_idle();
    drain();

    // zero-wait write then forwarded read of the same word
    issue(1'b1, 32'h10, 3'd2, 32'hDEADBEEF, 3'd0, 1'b1, 1'b0, 32'd0);
    issue(1'b0, 32'h10, 3'd2, 32'd0, 3'd0, 1'b1, 1'b1, 32'hDEADBEEF);
    go_idle();
    drain();

    issue(1'b0, 32'h10, 3'd2, 32'd0, 3'd3, 1'b1, 1'b1, 32'hDEADBEEF);
    go_idle();
    drain();

    issue(1'b1, 32'h10, 3'd2, 32'h11223344, 3'd0, 1'b1, 1'b0, 32'd0);
    issue(1'b1, 32'h13, 3'd0, 32'hAA000000, 3'd0, 1'b1, 1'b0, 32'd0);
    issue(1'b0, 32'h10, 3'd2, 32'd0, 3'd0, 1'b1, 1'b1, 32'hAA223344);
    issue(1'b0, 32'(DEPTH * 4), 3'd2, 32'd0, 3'd0, 1'b1, 1'b0, 32'd0);
    issue(1'b0, 32'h10, 3'd2, 32'd0, 3'd0, 1'b1, 1'b1, 32'hAA223344);
    issue(1'b1, 32'h11, 3'd1, 32'h00BEEF00, 3'd2, 1'b1, 1'b0, 32'd0);
    issue(1'b0, 32'h10, 3'd2, 32'd0, 3'd1, 1'b1, 1'b1, 32'hAA223344);
    hsel   = 1'b1;
    htrans = 2'd0;
    repeat (2) begin @(posedge clk); #1; end
    htrans = 2'd1;
    @(posedge clk); #1;
    go_idle();
    drain();

    // another slave stalls the bus while this one is not selected
    hsel      = 1'b0;
    htrans    = 2'd2;
    haddr     = 32'h20;
    force_low = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    force_low = 1'b0;
    go_idle();
    drain();

    // reset while a write sits in its wait states: the write must be dropped
    issue(1'b1, 32'h10, 3'd2, 32'h55AA55AA, 3'd5, 1'b0, 1'b0, 32'd0);
    go_idle();
    @(posedge clk); #1;
    hrst = 1'b1;
    @(posedge clk); #1;
    hrst = 1'b0;
    issue(1'b0, 32'h10, 3'd2, 32'd0, 3'd0, 1'b1, 1'b1, 32'hAA223344);
    go_idle();
    drain();

    for (int t = 0; t < 400; t++) begin
      kind = int'($urandom_range(0, 99));
      cw   = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'($urandom_range(1, 7));
      if (kind < 12) begin
        hsel   = 1'($urandom_range(0, 1));
        htrans = 2'($urandom_range(0, 1));
        @(posedge clk); #1;
      end else if (kind < 27) begin
        case ($urandom_range(0, 2))
          0: begin
            sz = 3'd2;
            a  = 32'(DEPTH * 4) + 32'($urandom_range(0, 1000) << 2);
          end
          1: begin
            sz = 3'($urandom_range(3, 7));
            a  = 32'($urandom_range(0, 127) << 3);
          end
          default: begin
            sz = 3'($urandom_range(1, 2));
            if (sz == 3'd1) a = 32'($urandom_range(0, 255) << 2) + 32'($urandom_range(0, 1) * 2 + 1);
            else a = 32'($urandom_range(0, 255) << 2) + 32'($urandom_range(1, 3));
          end
        endcase
        issue(1'($urandom_range(0, 1)), a, sz, $urandom(), cw, 1'b1, 1'b0, 32'd0);
      end else begin
        sz = 3'($urandom_range(0, 2));
        if ($urandom_range(0, 1) == 0) a = 32'($urandom_range(0, 15) * 4);
        else a = 32'($urandom_range(0, DEPTH - 1) * 4);
        a = a + ((32'($urandom_range(0, 3)) >> sz) << sz);
        issue(1'($urandom_range(0, 1)), a, sz, $urandom(), cw, 1'b1, 1'b0, 32'd0);
      end
    end
    go_idle();
    drain();

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
